// File: rtl/lot_gate_decoder.sv
// Parking-gate beam decoder: synchronises and debounces the outer/inner beams, tracks full passes.
// Optional LOT_GATE_ERR_EN adds err pulse and saturating err_cnt outputs for CLR entries.
module lot_gate_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       inc,
    output logic       dec,
    output logic       busy
`ifdef LOT_GATE_ERR_EN
    ,
    output logic       err,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        EN1,
        EN2,
        EN3,
        EX1,
        EX2,
        EX3,
        CLR
    } state_t;

    logic          a_m, a_s, b_m, b_s;
    logic [1:0]    s;
    logic [1:0]    filt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    state_t        state, ns;
    logic          inc_n, dec_n;
    logic          timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_m <= 1'b0;
            a_s <= 1'b0;
            b_m <= 1'b0;
            b_s <= 1'b0;
        end else begin
            a_m <= a_raw;
            a_s <= a_m;
            b_m <= b_raw;
            b_s <= b_m;
        end
    end

    assign s = {a_s, b_s};

    // Single counter for both bits: a change in s mid-count does not restart it.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= '0;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        ns    = state;
        inc_n = 1'b0;
        dec_n = 1'b0;
        case (state)
            IDLE: begin
                case (filt)
                    2'b10:   ns = EN1;
                    2'b01:   ns = EX1;
                    2'b00:   ns = IDLE;
                    default: ns = CLR;
                endcase
            end
            EN1: begin
                case (filt)
                    2'b11:   ns = EN2;
                    2'b00:   ns = IDLE;
                    2'b10:   ns = EN1;
                    default: ns = CLR;
                endcase
            end
            EN2: begin
                case (filt)
                    2'b01:   ns = EN3;
                    2'b10:   ns = EN1;
                    2'b11:   ns = EN2;
                    default: ns = CLR;
                endcase
            end
            EN3: begin
                case (filt)
                    2'b00: begin
                        ns    = IDLE;
                        inc_n = 1'b1;
                    end
                    2'b11:   ns = EN2;
                    2'b01:   ns = EN3;
                    default: ns = CLR;
                endcase
            end
            EX1: begin
                case (filt)
                    2'b11:   ns = EX2;
                    2'b00:   ns = IDLE;
                    2'b01:   ns = EX1;
                    default: ns = CLR;
                endcase
            end
            EX2: begin
                case (filt)
                    2'b10:   ns = EX3;
                    2'b01:   ns = EX1;
                    2'b11:   ns = EX2;
                    default: ns = CLR;
                endcase
            end
            EX3: begin
                case (filt)
                    2'b00: begin
                        ns    = IDLE;
                        dec_n = 1'b1;
                    end
                    2'b11:   ns = EX2;
                    2'b10:   ns = EX3;
                    default: ns = CLR;
                endcase
            end
            CLR: begin
                if (filt == 2'b00) ns = IDLE;
            end
            default: ns = CLR;
        endcase

        // Timeout overrides whatever the sensors asked for, including a completing pass.
        timeout = (state != IDLE) && (state != CLR) && (tcnt == TCNT_LAST);
        if (timeout) begin
            ns    = CLR;
            inc_n = 1'b0;
            dec_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcnt  <= '0;
            inc   <= 1'b0;
            dec   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= ns;
            if ((ns != state) || (state == IDLE) || (state == CLR)) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);
            inc  <= inc_n;
            dec  <= dec_n;
            busy <= (ns != IDLE);
        end
    end

`ifdef LOT_GATE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= (ns == CLR) && (state != CLR);
            if ((ns == CLR) && (state != CLR) && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lot_gate_decoder.sv
// Scoreboard bench for lot_gate_decoder: expected pulses (kind, cycle) queued at stimulus time.
// Builds with or without LOT_GATE_ERR_EN.
module tb_lot_gate_decoder;

    typedef struct {
        logic [1:0] kind;  // {inc,dec}
        int         cyc;
    } exp_t;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] INC  = 2'b10;
    localparam logic [1:0] DEC  = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic inc, dec, busy;
`ifdef LOT_GATE_ERR_EN
    logic       err;
    logic [7:0] err_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    lot_gate_decoder #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .inc  (inc),
        .dec  (dec),
        .busy (busy)
`ifdef LOT_GATE_ERR_EN
        ,
        .err    (err),
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse cycle is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (inc || dec) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got {inc,dec}=%b at cycle %0d, required none", {inc, dec}, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({inc, dec} !== e.kind || cyc !== e.cyc) begin
                    fails++;
                    $display("FAIL pulse: got {inc,dec}=%b at cycle %0d, required %b at cycle %0d",
                             {inc, dec}, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drive ab at a negedge, optionally queue the pulse expected 7 edges later, hold for 'hold' cycles.
    task automatic step(input logic [1:0] ab, input int hold, input logic [1:0] kind);
        @(negedge clk);
        a_raw = ab[1];
        b_raw = ab[0];
        if (kind != NONE) exp_q.push_back('{kind: kind, cyc: cyc + 7});
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({inc, dec, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got {inc,dec,busy}=%b, required 000", {inc, dec, busy});
        end
`ifdef LOT_GATE_ERR_EN
        tests++;
        if ({err, err_cnt} !== 9'd0) begin
            fails++;
            $display("FAIL reset_err: got err=%b err_cnt=%0d, required 0/0", err, err_cnt);
        end
`endif
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_entry();
        step(2'b10, 10, NONE);
        step(2'b11, 10, NONE);
        step(2'b01, 10, NONE);
        step(2'b00, 12, INC);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL entry_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL entry_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_exit();
        step(2'b01, 10, NONE);
        step(2'b11, 10, NONE);
        step(2'b10, 10, NONE);
        step(2'b00, 12, DEC);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL exit_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL exit_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_back_out();
        step(2'b10, 10, NONE);
        step(2'b11, 10, NONE);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL backout_busy_mid: got %b, required 1", busy);
        end
        step(2'b10, 10, NONE);
        step(2'b00, 12, NONE);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL backout_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        @(negedge clk);
        a_raw = 1'b1;
        b_raw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= busy;
        end
        a_raw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= busy;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy: got busy seen=%b, required 0", seen);
        end
    endtask

    task automatic test_illegal_jump();
`ifdef LOT_GATE_ERR_EN
        logic [7:0] cnt0 = err_cnt;
`endif
        step(2'b11, 12, NONE);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL illegal_clr_busy: got %b, required 1", busy);
        end
`ifdef LOT_GATE_ERR_EN
        tests++;
        if (err_cnt !== cnt0 + 8'd1) begin
            fails++;
            $display("FAIL illegal_err_cnt: got %0d, required %0d", err_cnt, cnt0 + 8'd1);
        end
`endif
        step(2'b00, 12, NONE);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL illegal_recover_busy: got %b, required 0", busy);
        end
    endtask

    // EN1 held 49 cycles completes; 50 cycles times out and the rest of the pass is ignored.
    task automatic test_timeout_boundary();
        step(2'b10, 49, NONE);
        step(2'b11, 10, NONE);
        step(2'b01, 10, NONE);
        step(2'b00, 12, INC);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL timeout_49_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        step(2'b10, 50, NONE);
        step(2'b11, 10, NONE);
        step(2'b01, 10, NONE);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_50_clr_busy: got %b, required 1", busy);
        end
        step(2'b00, 12, NONE);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_50_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_stall();
        step(2'b10, 80, NONE);
        step(2'b11, 10, NONE);
        step(2'b01, 10, NONE);
        step(2'b00, 12, NONE);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_pass();
        step(2'b10, 10, NONE);
        step(2'b11, 10, NONE);
        step(2'b01, 10, NONE);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_busy_before: got %b, required 1", busy);
        end
        @(negedge clk);
        rst   = 1'b1;
        a_raw = 1'b0;
        b_raw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({inc, dec, busy} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_outputs: got {inc,dec,busy}=%b, required 000", {inc, dec, busy});
        end
        repeat (20) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_busy_after: got %b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            step(2'b10, 10, NONE);
            step(2'b11, 10, NONE);
            step(2'b01, 10, NONE);
            step(2'b00, 10, INC);
        end
        step(2'b01, 10, NONE);
        step(2'b11, 10, NONE);
        step(2'b10, 10, NONE);
        step(2'b00, 12, DEC);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_missing: got %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_back_out();
        test_glitch();
        test_illegal_jump();
        test_timeout_boundary();
        test_stall();
        test_reset_mid_pass();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lot_gate_decoder.md
Name: lot_gate_decoder

Overview:
- Converts the two photo-sensor beams at the parking lot gate into single-cycle inc/dec pulses for the lot occupancy counter.
- Sensor a is the outer beam and sensor b is the inner beam. A sensor reads 1 when the beam is blocked.
- A car entering blocks a, then a+b, then b, then neither; exiting is the mirror sequence.
- The block synchronises and debounces both sensors, then tracks each full pass with an FSM. Partial passes, back-outs, illegal jumps and stalls produce no pulse.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clk cycles a synchronised sensor pair must hold a new value before the filtered value accepts it. Legal range is ≥1.
- TIMEOUT_CYCLES, 1000: maximum clk cycles the FSM may stay in any single non-IDLE state before the pass is abandoned. Legal range is ≥2.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- a_raw, in, 1: outer sensor, asynchronous, 1 = blocked.
- b_raw, in, 1: inner sensor, asynchronous, 1 = blocked.
- inc, out, 1: registered one-cycle pulse meaning one car fully entered.
- dec, out, 1: registered one-cycle pulse meaning one car fully exited.
- busy, out, 1: registered; high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops, filt[1:0]={a,b}, debounce counter, timeout counter, inc, dec, busy all cleared to 0.
  - FSM state set to IDLE.
  - Reset mid-pass discards the pass; no pulse is issued.
- Synchroniser: two-flop chain per sensor; the output is s={a_s,b_s}.
- Debounce:
  - While s==filt, cnt=0.
  - Otherwise cnt increments each cycle.
  - At the edge where cnt==DEBOUNCE_CYCLES-1 and s!=filt: filt<=s and cnt<=0.
  - Both bits update together, so a change in s restarts nothing; cnt keeps counting against the current filt.
- Latency: for raw inputs stable from edge k, filt updates at edge k+1+DEBOUNCE_CYCLES. The FSM and pulses update at edge k+2+DEBOUNCE_CYCLES.
- FSM transitions, evaluated on filt. Any filt value not listed for the current state goes to CLR.
  - IDLE: 10→EN1, 01→EX1, 00 stay, 11→CLR.
  - EN1: 11→EN2, 00→IDLE (back-out), 10 stay.
  - EN2: 01→EN3, 10→EN1, 11 stay.
  - EN3: 00→IDLE with inc<=1; 11→EN2; 01 stay.
  - EX1: 11→EX2, 00→IDLE, 01 stay.
  - EX2: 10→EX3, 01→EX1, 11 stay.
  - EX3: 00→IDLE with dec<=1; 11→EX2; 10 stay.
  - CLR: 00→IDLE with no pulse; otherwise stay.
- Pulses:
  - inc and dec are high for exactly one cycle, only on the EN3→IDLE or EX3→IDLE transition.
  - inc and dec are never high together.
  - They are never high two consecutive cycles, because a re-entry needs at least one filt change.
- Timeout:
  - tcnt clears on every state change and while in IDLE or CLR.
  - In any other state, when tcnt reaches TIMEOUT_CYCLES-1 the next edge moves to CLR and tcnt clears.
  - Timeout produces no pulse.
- busy is registered from the next-state value: busy = (ns != IDLE).

Optional Feature:
- Macro name: LOT_GATE_ERR_EN.
- When defined:
  - Adds an output port err, 1 bit, reset value 0.
  - err pulses high for one cycle on every entry into CLR, whether from an illegal transition or a timeout, aligned with the state update.
  - Adds a saturating 8-bit output err_cnt, reset value 0, which increments on each err pulse and holds at 255.
- When undefined:
  - Neither port exists.
  - All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, each raw step held 10 cycles):
- Entry: a,b = 00→10→11→01→00 → exactly one inc pulse, 6 edges after the final 00 is first sampled; dec=0 throughout; busy is 0 after the pulse.
- Exit: 00→01→11→10→00 → exactly one dec pulse, inc=0.
- Back-out: entry stepped 10→11→10→00 → no pulse; busy returns to 0.
- Glitches and illegal jump:
  - 10 glitch held 3 cycles then 00 → filt never changes, no busy.
  - 00→11 held → CLR (err=1 if LOT_GATE_ERR_EN); then 00 → IDLE with no pulse.
- Stall and reset:
  - Hold 10 for 80 cycles → CLR after 50 cycles in EN1; then 00 → no pulse.
  - Separately, assert rst for one cycle while in EN3 → IDLE, no inc, all outputs 0.
- Back-to-back: two complete entries followed by one complete exit → inc, inc, dec pulses in that order, each one cycle wide.
